// File: rtl/riscv_biu_arbiter.sv
// Shares one cache BIU request port between NREQ requesters.
// The grant is held until every data beat of the accepted burst completes.
module riscv_biu_arbiter #(
    parameter int ADDR     = 32,
    parameter int XLEN     = 32,
    parameter int NREQ     = 2,
    parameter int ARB_MODE = 0
) (
    input  logic                 HRESETn,
    input  logic                 HCLK,
    input  logic [NREQ-1:0]      m_stb,
    output logic [NREQ-1:0]      m_stb_ack,
    input  logic [NREQ*ADDR-1:0] m_adri,
    input  logic [NREQ*3-1:0]    m_type,
    input  logic [NREQ-1:0]      m_we,
    input  logic [NREQ-1:0]      m_lock,
    input  logic [NREQ*XLEN-1:0] m_d,
    output logic [XLEN-1:0]      m_q,
    output logic [NREQ-1:0]      m_rack,
    output logic [NREQ-1:0]      m_wack,
    output logic [NREQ-1:0]      m_err,
    output logic                 biu_stb,
    input  logic                 biu_stb_ack,
    output logic [ADDR-1:0]      biu_adri,
    output logic [2:0]           biu_type,
    output logic                 biu_we,
    output logic                 biu_lock,
    output logic [XLEN-1:0]      biu_d,
    input  logic [XLEN-1:0]      biu_q,
    input  logic                 biu_rack,
    input  logic                 biu_wack,
    input  logic                 biu_err
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_owner;
    logic [IW-1:0]   r_last;
    logic [4:0]      r_beats;
    logic            r_locked;
    logic [IW-1:0]   w_grant;
    logic [IW-1:0]   w_idx;
    logic [IW-1:0]   w_sel;
    logic            w_found;
    logic            w_take;
    logic            w_ack;

    function automatic logic [4:0] burst_beats(input logic [2:0] t);
        unique case (t[2:1])
            2'b00:   return 5'd1;
            2'b01:   return 5'd4;
            2'b10:   return 5'd8;
            default: return 5'd16;
        endcase
    endfunction

    // With nobody requesting, the grant falls back to the current owner.
    always_comb begin
        w_grant = r_owner;
        w_idx   = '0;
        w_found = 1'b0;
        if (r_locked) begin
            w_grant = r_owner;
        end else if (ARB_MODE == 0) begin
            for (int i = 1; i <= NREQ; i++) begin
                w_idx = IW'((int'(r_last) + i) % NREQ);
                if (!w_found && m_stb[w_idx]) begin
                    w_grant = w_idx;
                    w_found = 1'b1;
                end
            end
        end else begin
            for (int i = NREQ - 1; i >= 0; i--) begin
                w_idx = IW'(i);
                if (m_stb[w_idx]) begin
                    w_grant = w_idx;
                end
            end
        end
    end

    assign w_sel    = (r_state == IDLE) ? w_grant : r_owner;
    assign biu_adri = m_adri[w_sel*ADDR +: ADDR];
    assign biu_type = m_type[w_sel*3 +: 3];
    assign biu_we   = m_we[w_sel];
    assign biu_lock = m_lock[w_sel];
    assign biu_d    = m_d[w_sel*XLEN +: XLEN];
    assign m_q      = biu_q;
    assign w_take   = biu_stb & biu_stb_ack;
    assign w_ack    = biu_rack | biu_wack;

    always_comb begin
        biu_stb   = 1'b0;
        m_stb_ack = '0;
        m_rack    = '0;
        m_wack    = '0;
        m_err     = '0;
        if (HRESETn) begin
            if (r_state == IDLE) begin
                biu_stb            = m_stb[w_grant];
                m_stb_ack[w_grant] = m_stb[w_grant] & biu_stb_ack;
            end else begin
                m_rack[r_owner] = biu_rack;
                m_wack[r_owner] = biu_wack;
                m_err[r_owner]  = biu_err;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_take) w_next = BUSY;
            end
            BUSY: begin
                if (biu_err) w_next = IDLE;
                else if (w_ack && r_beats == 5'd1) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_last   <= IW'(NREQ - 1);
            r_beats  <= '0;
            r_locked <= 1'b0;
        end else begin
            r_state <= w_next;
            unique case (r_state)
                IDLE: begin
                    if (w_take) begin
                        r_owner  <= w_grant;
                        r_last   <= w_grant;
                        r_locked <= m_lock[w_grant];
                        r_beats  <= burst_beats(m_type[w_grant*3 +: 3]);
                    end else if (r_locked && !m_lock[r_owner]) begin
                        r_locked <= 1'b0;
                    end
                end
                BUSY: begin
                    if (biu_err) begin
                        r_beats  <= '0;
                        r_locked <= 1'b0;
                    end else if (w_ack && r_beats != 5'd0) begin
                        r_beats <= r_beats - 5'd1;
                    end
                end
                default: r_beats <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_biu_arbiter.sv
// Directed bench for riscv_biu_arbiter: a round-robin and a
// fixed-priority instance share stimulus; expectations are hand-computed.
module tb_riscv_biu_arbiter;

    localparam logic [31:0] A0 = 32'h1000_0000;
    localparam logic [31:0] A1 = 32'h2000_0040;
    localparam logic [31:0] D0 = 32'hAAAA_0000;
    localparam logic [31:0] D1 = 32'h5555_1111;

    logic        HRESETn;
    logic        HCLK;
    logic [1:0]  m_stb;
    logic [63:0] m_adri;
    logic [5:0]  m_type;
    logic [1:0]  m_we;
    logic [1:0]  m_lock;
    logic [63:0] m_d;
    logic        biu_stb_ack;
    logic [31:0] biu_q;
    logic        biu_rack;
    logic        biu_wack;
    logic        biu_err;

    logic [1:0]  a_m_stb_ack, a_m_rack, a_m_wack, a_m_err;
    logic [31:0] a_m_q, a_biu_adri, a_biu_d;
    logic [2:0]  a_biu_type;
    logic        a_biu_stb, a_biu_we, a_biu_lock;

    logic [1:0]  b_m_stb_ack, b_m_rack, b_m_wack, b_m_err;
    logic [31:0] b_m_q, b_biu_adri, b_biu_d;
    logic [2:0]  b_biu_type;
    logic        b_biu_stb, b_biu_we, b_biu_lock;

    int n_chk;
    int n_fail;

    riscv_biu_arbiter #(.ARB_MODE(0)) dut_a (
        .HRESETn(HRESETn), .HCLK(HCLK),
        .m_stb(m_stb), .m_stb_ack(a_m_stb_ack),
        .m_adri(m_adri), .m_type(m_type), .m_we(m_we),
        .m_lock(m_lock), .m_d(m_d), .m_q(a_m_q),
        .m_rack(a_m_rack), .m_wack(a_m_wack), .m_err(a_m_err),
        .biu_stb(a_biu_stb), .biu_stb_ack(biu_stb_ack),
        .biu_adri(a_biu_adri), .biu_type(a_biu_type),
        .biu_we(a_biu_we), .biu_lock(a_biu_lock), .biu_d(a_biu_d),
        .biu_q(biu_q), .biu_rack(biu_rack), .biu_wack(biu_wack),
        .biu_err(biu_err)
    );

    riscv_biu_arbiter #(.ARB_MODE(1)) dut_b (
        .HRESETn(HRESETn), .HCLK(HCLK),
        .m_stb(m_stb), .m_stb_ack(b_m_stb_ack),
        .m_adri(m_adri), .m_type(m_type), .m_we(m_we),
        .m_lock(m_lock), .m_d(m_d), .m_q(b_m_q),
        .m_rack(b_m_rack), .m_wack(b_m_wack), .m_err(b_m_err),
        .biu_stb(b_biu_stb), .biu_stb_ack(biu_stb_ack),
        .biu_adri(b_biu_adri), .biu_type(b_biu_type),
        .biu_we(b_biu_we), .biu_lock(b_biu_lock), .biu_d(b_biu_d),
        .biu_q(biu_q), .biu_rack(biu_rack), .biu_wack(biu_wack),
        .biu_err(biu_err)
    );

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic step;
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle_in;
        m_stb       = 2'b00;
        m_lock      = 2'b00;
        m_we        = 2'b00;
        m_type      = 6'b0;
        biu_stb_ack = 1'b0;
        biu_rack    = 1'b0;
        biu_wack    = 1'b0;
        biu_err     = 1'b0;
    endtask

    task automatic do_reset;
        idle_in();
        HRESETn = 1'b0;
        #2;
        HRESETn = 1'b1;
    endtask

    logic [1:0] exp_g;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        m_adri = {A1, A0};
        m_d    = {D1, D0};
        biu_q  = 32'h0;
        idle_in();
        HRESETn = 1'b0;

        // Test 1: reset outputs, then single-requester INCR4 read
        m_stb       = 2'b01;
        biu_stb_ack = 1'b1;
        #2;
        chk("rst_stb", 64'(a_biu_stb), 64'h0);
        chk("rst_ack", 64'(a_m_stb_ack), 64'h0);
        chk("rst_rack", 64'(a_m_rack), 64'h0);
        step();
        HRESETn = 1'b1;
        m_type  = 6'b000_011;
        #2;
        chk("t1_stb", 64'(a_biu_stb), 64'h1);
        chk("t1_ack", 64'(a_m_stb_ack), 64'h1);
        chk("t1_adr", 64'(a_biu_adri), 64'(A0));
        chk("t1_type", 64'(a_biu_type), 64'h3);
        step();
        m_stb       = 2'b00;
        biu_stb_ack = 1'b0;
        #2;
        chk("t1_busy_stb", 64'(a_biu_stb), 64'h0);
        chk("t1_busy_ack", 64'(a_m_stb_ack), 64'h0);
        for (int i = 0; i < 4; i++) begin
            step();
            biu_rack = 1'b1;
            biu_q    = 32'hC0DE_0000 + 32'(i);
            #2;
            chk("t1_rack", 64'(a_m_rack), 64'h1);
            chk("t1_q", 64'(a_m_q), 64'(32'hC0DE_0000 + 32'(i)));
        end
        step();
        #2;
        chk("t1_idle_rack", 64'(a_m_rack), 64'h0);

        // Test 2: both requesting SINGLE; RR alternates, fixed stays on 0
        step();
        do_reset();
        step();
        m_stb       = 2'b11;
        biu_stb_ack = 1'b1;
        biu_rack    = 1'b1;
        #2;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2) ? 2'b10 : 2'b01;
            chk("t2_rr_grant", 64'(a_m_stb_ack), 64'(exp_g));
            chk("t2_fp_grant", 64'(b_m_stb_ack), 64'h1);
            step();
            #2;
            chk("t2_rr_rack", 64'(a_m_rack), 64'(exp_g));
            chk("t2_fp_rack", 64'(b_m_rack), 64'h1);
            step();
            #2;
        end

        // Test 3: fixed priority, no preemption of a WRAP8 write
        do_reset();
        step();
        m_stb       = 2'b10;
        m_type      = 6'b100_000;
        m_we        = 2'b10;
        biu_stb_ack = 1'b1;
        #2;
        chk("t3_grant1", 64'(b_m_stb_ack), 64'h2);
        chk("t3_we", 64'(b_biu_we), 64'h1);
        for (int i = 0; i < 8; i++) begin
            step();
            if (i == 0) m_stb = 2'b00;
            if (i == 3) m_stb = 2'b01;
            biu_wack = 1'b1;
            #2;
            chk("t3_wack", 64'(b_m_wack), 64'h2);
            chk("t3_wdata", 64'(b_biu_d), 64'(D1));
            if (i >= 3) begin
                chk("t3_nopreempt", 64'(b_m_stb_ack), 64'h0);
            end
        end
        step();
        biu_wack = 1'b0;
        #2;
        chk("t3_grant0", 64'(b_m_stb_ack), 64'h1);
        chk("t3_adr0", 64'(b_biu_adri), 64'(A0));

        // Test 4: error at beat 5 of INCR16 ends the burst
        do_reset();
        step();
        m_stb       = 2'b10;
        m_type      = 6'b111_000;
        biu_stb_ack = 1'b1;
        #2;
        chk("t4_grant1", 64'(a_m_stb_ack), 64'h2);
        for (int i = 0; i < 5; i++) begin
            step();
            m_stb = 2'b01;
            if (i < 4) begin
                biu_rack = 1'b1;
            end else begin
                biu_rack = 1'b0;
                biu_err  = 1'b1;
            end
            #2;
            if (i < 4) chk("t4_rack", 64'(a_m_rack), 64'h2);
            else chk("t4_err", 64'(a_m_err), 64'h2);
            chk("t4_wait0", 64'(a_m_stb_ack), 64'h0);
        end
        step();
        biu_err = 1'b0;
        #2;
        chk("t4_err_clr", 64'(a_m_err), 64'h0);
        chk("t4_grant0", 64'(a_m_stb_ack), 64'h1);

        // Test 5: locked pair of SINGLEs from requester 0
        do_reset();
        step();
        m_stb       = 2'b11;
        m_lock      = 2'b01;
        biu_stb_ack = 1'b1;
        #2;
        chk("t5_grant_a", 64'(a_m_stb_ack), 64'h1);
        step();
        biu_rack = 1'b1;
        #2;
        chk("t5_rack_a", 64'(a_m_rack), 64'h1);
        chk("t5_lock_out", 64'(a_biu_lock), 64'h1);
        step();
        #2;
        chk("t5_grant_b", 64'(a_m_stb_ack), 64'h1);
        step();
        m_stb  = 2'b10;
        m_lock = 2'b00;
        #2;
        chk("t5_rack_b", 64'(a_m_rack), 64'h1);
        step();
        #2;
        chk("t5_unlock", 64'(a_m_stb_ack), 64'h0);
        step();
        #2;
        chk("t5_grant1", 64'(a_m_stb_ack), 64'h2);

        // Test 6: asynchronous reset during beat 2 of INCR4
        do_reset();
        step();
        m_stb       = 2'b10;
        m_type      = 6'b011_000;
        biu_stb_ack = 1'b1;
        #2;
        chk("t6_grant1", 64'(a_m_stb_ack), 64'h2);
        step();
        m_stb    = 2'b11;
        biu_rack = 1'b1;
        #2;
        chk("t6_beat1", 64'(a_m_rack), 64'h2);
        step();
        #2;
        chk("t6_beat2", 64'(a_m_rack), 64'h2);
        HRESETn = 1'b0;
        #1;
        chk("t6_rst_stb", 64'(a_biu_stb), 64'h0);
        chk("t6_rst_ack", 64'(a_m_stb_ack), 64'h0);
        chk("t6_rst_rack", 64'(a_m_rack), 64'h0);
        chk("t6_rst_owner", 64'(dut_a.r_owner), 64'h0);
        chk("t6_rst_last", 64'(dut_a.r_last), 64'h1);
        #1;
        HRESETn = 1'b1;
        #1;
        chk("t6_post_rack", 64'(a_m_rack), 64'h0);
        chk("t6_post_grant", 64'(a_m_stb_ack), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
